dct_out_writer: RTL and testbench



---
 rtl/dct_out_writer_if.sv | 17 +
 rtl/dct_out_writer.sv | 111 +++++++++++
 tb/tb_dct_out_writer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/dct_out_writer_if.sv
// Pin bundle of the single-port DCT output memory (RA/CA addressing, active-low NCE/NWRT).
// The controller drives the master side; the memory macro sits on the slave side.
interface dct_out_writer_if #(
  parameter int DATA_W = 192,
  parameter int ADDR_W = 14,
  parameter int CA_W   = 4
);
  logic [DATA_W-1:0]      d;
  logic [DATA_W-1:0]      q;
  logic [ADDR_W-CA_W-1:0] ra;
  logic [CA_W-1:0]        ca;
  logic                   nwrt;
  logic                   nce;

  modport master (output d, ra, ca, nwrt, nce, input q);
  modport slave  (input d, ra, ca, nwrt, nce, output q);
endinterface

// File: rtl/dct_out_writer.sv
// Write-side controller for the DCT output memory: stores one frame of coefficient
// vectors in arrival order, then serves random-access readback over the same port.
module dct_out_writer #(
  parameter int DATA_W    = 192,
  parameter int ADDR_W    = 14,
  parameter int CA_W      = 4,
  parameter int FRAME_LEN = 16384
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                rd_req,
  input  logic [ADDR_W-1:0]   rd_addr,
  dct_out_writer_if.master    mem,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [ADDR_W:0]     wr_count
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W+1)'(FRAME_LEN - 1);
  localparam logic [ADDR_W:0] FRAME_CNT = (ADDR_W+1)'(FRAME_LEN);

  state_t              state;
  state_t              state_next;
  logic                do_write;
  logic                do_read;
  logic                drop;
  logic                nce_q;
  logic                nwrt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   d_q;
  logic                rd_issued;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // start overrides everything else in its cycle, so nothing is written, read or dropped
  always_comb begin
    state_next = state;
    do_write   = 1'b0;
    do_read    = 1'b0;
    drop       = 1'b0;
    if (start) begin
      state_next = FILL;
    end else begin
      unique case (state)
        IDLE: drop = in_valid;
        FILL: begin
          do_write = in_valid;
          if (in_valid && wr_count == LAST_IDX) state_next = DONE;
        end
        DONE: begin
          drop    = in_valid;
          do_read = rd_req;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_count  <= '0;
      overflow  <= 1'b0;
      nce_q     <= 1'b1;
      nwrt_q    <= 1'b1;
      addr_q    <= '0;
      d_q       <= '0;
      rd_issued <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      nce_q     <= ~(do_write | do_read);
      nwrt_q    <= ~do_write;
      rd_issued <= do_read;
      rd_valid  <= rd_issued;
      // Address and data registers hold whenever no command is issued
      if (do_write) begin
        d_q    <= in_data;
        addr_q <= wr_count[ADDR_W-1:0];
      end else if (do_read) begin
        addr_q <= rd_addr;
      end
      if (start) begin
        wr_count <= '0;
        overflow <= 1'b0;
      end else begin
        if (do_write && wr_count != FRAME_CNT) wr_count <= wr_count + 1'b1;
        if (drop) overflow <= 1'b1;
      end
    end
  end

  assign mem.nce  = nce_q;
  assign mem.nwrt = nwrt_q;
  assign mem.d    = d_q;
  assign mem.ra   = addr_q[ADDR_W-1:CA_W];
  assign mem.ca   = addr_q[CA_W-1:0];
  assign rd_data  = mem.q;
  assign busy     = (state == FILL);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_dct_out_writer.sv
// Self-checking bench for dct_out_writer: a behavioural memory macro on the port and a
// frame-level reference model predicting every output cycle by cycle.
module tb_dct_out_writer;
  localparam int DATA_W    = 192;
  localparam int ADDR_W    = 14;
  localparam int CA_W      = 4;
  localparam int FRAME_LEN = 16384;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic                in_valid;
  logic [DATA_W-1:0]   in_data;
  logic                rd_req;
  logic [ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_valid;
  logic                busy;
  logic                done;
  logic                overflow;
  logic [ADDR_W:0]     wr_count;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  dct_out_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CA_W(CA_W)) mem_if ();

  dct_out_writer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CA_W(CA_W), .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .mem(mem_if), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .done(done), .overflow(overflow), .wr_count(wr_count)
  );

  // Memory macro: latches D on a write command, registers Q one cycle after a read command
  logic [DATA_W-1:0] macro_mem [FRAME_LEN];
  always @(posedge clk) begin
    if (!mem_if.nce && !mem_if.nwrt) macro_mem[{mem_if.ra, mem_if.ca}] <= mem_if.d;
    if (!mem_if.nce && mem_if.nwrt)  mem_if.q <= macro_mem[{mem_if.ra, mem_if.ca}];
  end

  // Reference model: frame mode, counters and what the memory should hold
  typedef enum {M_IDLE, M_FILL, M_DONE} mode_t;
  mode_t             mode = M_IDLE;
  int                count = 0;
  bit                ovf = 1'b0;
  bit                e_nce = 1'b1;
  bit                e_nwrt = 1'b1;
  logic [ADDR_W-1:0] e_addr = '0;
  logic [DATA_W-1:0] e_d = '0;
  bit                e_rd_valid = 1'b0;
  logic [DATA_W-1:0] e_rd_data = '0;
  bit                read_on_pins = 1'b0;
  logic [DATA_W-1:0] pend_data = '0;
  logic [DATA_W-1:0] ref_mem [FRAME_LEN];

  function automatic logic [DATA_W-1:0] rndVec();
    logic [DATA_W-1:0] v;
    for (int k = 0; k < DATA_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic modelStep();
    bit wr;
    bit rd;
    e_rd_valid = read_on_pins && !reset;
    e_rd_data  = pend_data;
    if (reset) begin
      mode = M_IDLE; count = 0; ovf = 1'b0;
      e_nce = 1'b1; e_nwrt = 1'b1; e_addr = '0; e_d = '0;
      read_on_pins = 1'b0;
    end else begin
      wr = !start && mode == M_FILL && in_valid;
      rd = !start && mode == M_DONE && rd_req;
      if (!start && in_valid && mode != M_FILL) ovf = 1'b1;
      e_nce  = !(wr || rd);
      e_nwrt = !wr;
      if (wr) begin
        e_addr = ADDR_W'(count);
        e_d    = in_data;
        ref_mem[count] = in_data;
        count++;
        if (count == FRAME_LEN) mode = M_DONE;
      end
      if (rd) begin
        e_addr    = rd_addr;
        pend_data = ref_mem[rd_addr];
      end
      read_on_pins = rd;
      if (start) begin
        mode = M_FILL; count = 0; ovf = 1'b0;
      end
    end
  endtask

  task automatic compare(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    compare("nce", DATA_W'(mem_if.nce), DATA_W'(e_nce));
    compare("nwrt", DATA_W'(mem_if.nwrt), DATA_W'(e_nwrt));
    compare("addr", DATA_W'({mem_if.ra, mem_if.ca}), DATA_W'(e_addr));
    compare("mem_d", mem_if.d, e_d);
    compare("rd_valid", DATA_W'(rd_valid), DATA_W'(e_rd_valid));
    if (e_rd_valid) compare("rd_data", rd_data, e_rd_data);
    compare("busy", DATA_W'(busy), DATA_W'(mode == M_FILL));
    compare("done", DATA_W'(done), DATA_W'(mode == M_DONE));
    compare("overflow", DATA_W'(overflow), DATA_W'(ovf));
    compare("wr_count", DATA_W'(wr_count), DATA_W'(count));
  endtask

  // Called at a falling edge: drive, predict the next rising edge, check at the next falling edge
  task automatic applyStimulus(input bit r, input bit s, input bit v, input logic [DATA_W-1:0] d,
                               input bit q, input logic [ADDR_W-1:0] a);
    reset = r; start = s; in_valid = v; in_data = d; rd_req = q; rd_addr = a;
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, rndVec(), 1'b0, ADDR_W'($urandom));
  endtask

  initial begin
    logic [11:0] lane;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; rd_req = 1'b0; rd_addr = '0;
    @(negedge clk);

    // Reset dominates any other input
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rndVec(),
                    1'($urandom_range(0, 1)), ADDR_W'($urandom));

    // IDLE: in_valid dropped and flagged, rd_req ignored
    applyStimulus(1'b0, 1'b0, 1'b1, rndVec(), 1'b1, ADDR_W'($urandom));
    idleCycle();

    // Full frame, lanes carry the low address bits
    applyStimulus(1'b0, 1'b1, 1'b0, rndVec(), 1'b0, '0);
    for (int i = 0; i < FRAME_LEN; i++) begin
      lane = 12'(i);
      applyStimulus(1'b0, 1'b0, 1'b1, {16{lane}}, 1'b0, ADDR_W'($urandom));
    end
    idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, rndVec(), 1'b0, '0);

    // Readback including first and last word, with stray in_valid mixed in
    applyStimulus(1'b0, 1'b0, 1'b0, rndVec(), 1'b1, ADDR_W'(FRAME_LEN - 1));
    applyStimulus(1'b0, 1'b0, 1'b0, rndVec(), 1'b1, '0);
    for (int i = 0; i < 30; i++)
      applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), rndVec(),
                    1'($urandom_range(0, 3) != 0), ADDR_W'($urandom));
    idleCycle();
    idleCycle();

    // start with simultaneous in_valid/rd_req: ignored, overflow cleared
    applyStimulus(1'b0, 1'b1, 1'b1, rndVec(), 1'b1, ADDR_W'($urandom));
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, rndVec(), 1'b0, '0);

    // Restart mid-frame at wr_count=5
    applyStimulus(1'b0, 1'b1, 1'b1, rndVec(), 1'b0, '0);
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 3) != 0 || i == 0), rndVec(), 1'b0, '0);
    while (count < 10) applyStimulus(1'b0, 1'b0, 1'b1, rndVec(), 1'b0, '0);

    // Reset at wr_count=10 with a write in the same cycle, then reads give nothing
    applyStimulus(1'b1, 1'b0, 1'b1, rndVec(), 1'b1, ADDR_W'($urandom));
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, rndVec(), 1'b1, ADDR_W'($urandom));

    // Random frame with gaps, then random readback
    applyStimulus(1'b0, 1'b1, 1'b0, rndVec(), 1'b0, '0);
    for (int i = 0; i < 4 * FRAME_LEN && count < FRAME_LEN; i++)
      applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 3) != 0), rndVec(),
                    1'($urandom_range(0, 1)), ADDR_W'($urandom));
    for (int i = 0; i < 60; i++)
      applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 4) == 0), rndVec(),
                    1'($urandom_range(0, 3) != 0), ADDR_W'($urandom));
    idleCycle();
    idleCycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
